// File: rtl/instr_fetch_pkg.sv
// Shared widths, default halt word and fetch state encoding for the instruction fetch unit.
package instr_fetch_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] HALT_WORD_DEF = 16'hFFFF;

   typedef enum logic [1:0] {
      FS_IDLE    = 2'd0,
      FS_FETCH   = 2'd1,
      FS_HALTED  = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {word, fetch address}; flush beats push and pop.
module instr_fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [ADDR_W-1:0]     wr_pc,
   output logic [DATA_W-1:0]     rd_data,
   output logic [ADDR_W-1:0]     rd_pc,
   output logic [$clog2(DEPTH):0] count,
   output logic                  empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] data_r [DEPTH];
   logic [ADDR_W-1:0] pc_r   [DEPTH];
   logic [PW-1:0]     rd_ptr_r;
   logic [PW-1:0]     wr_ptr_r;
   logic [CW-1:0]     count_r;
   logic              full_s;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign full_s    = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign rd_data   = data_r[rd_ptr_r];
   assign rd_pc     = pc_r[rd_ptr_r];
   // a push into a full buffer is only legal when the head leaves in the same cycle
   assign push_ok_s = push & (~full_s | pop_ok_s);
   assign pop_ok_s  = pop & ~empty;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_r[i] <= {DATA_W{1'b0}};
            pc_r[i]   <= {ADDR_W{1'b0}};
         end
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            data_r[wr_ptr_r] <= wr_data;
            pc_r[wr_ptr_r]   <= wr_pc;
            wr_ptr_r         <= wr_ptr_r + 1'b1;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, fetch state machine, prefetch buffer feeding decode, redirect and halt.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
   parameter int                DEPTH     = 2,
   parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        halted
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t      state_r;
   fetch_state_t      state_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_s;
   logic              halted_r;
   logic              pop_s;
   logic              capture_s;
   logic [CW-1:0]     fifo_count_s;
   logic              fifo_empty_s;

   assign mem_addr    = pc_r;
   assign instr_valid = ~fifo_empty_s;
   assign halted      = halted_r;

   instr_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (capture_s),
      .pop     (pop_s),
      .flush   (redirect),
      .wr_data (mem_data),
      .wr_pc   (pc_r),
      .rd_data (instr),
      .rd_pc   (instr_pc),
      .count   (fifo_count_s),
      .empty   (fifo_empty_s)
   );

   // Capture and pop qualification; a full buffer still accepts a word when the head leaves.
   always_comb begin
      pop_s     = instr_valid & instr_ready;
      capture_s = 1'b0;
      if ((state_r == FS_FETCH) && !redirect && ((fifo_count_s < CW'(DEPTH)) || pop_s)) begin
         capture_s = 1'b1;
      end else begin
         capture_s = 1'b0;
      end
   end

   // Next state and next PC; redirect overrides start and halt.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      if (redirect) begin
         state_s = FS_FETCH;
         pc_s    = redirect_pc;
      end else begin
         if (capture_s) begin
            pc_s = pc_r + 16'd1;
         end else begin
            pc_s = pc_r;
         end
         case (state_r)
            FS_IDLE: begin
               if (start) begin
                  state_s = FS_FETCH;
               end else begin
                  state_s = FS_IDLE;
               end
            end
            FS_FETCH: begin
               if (capture_s && (mem_data == HALT_WORD)) begin
                  state_s = FS_HALTED;
               end else begin
                  state_s = FS_FETCH;
               end
            end
            FS_HALTED: state_s = FS_HALTED;
            default:   state_s = FS_IDLE;
         endcase
      end
   end

   // State, PC and halted flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= FS_IDLE;
         pc_r     <= RESET_PC;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         pc_r     <= pc_s;
         halted_r <= (state_s == FS_HALTED);
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic against a queue model.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        redirect;
   logic        instr_ready;
   logic [15:0] redirect_pc;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        halted;

   typedef struct packed {
      logic [15:0] data;
      logic [15:0] pc;
   } ent_t;

   localparam int DEPTH = 2;

   int          n_checks = 0;
   int          n_fail   = 0;
   ent_t        q[$];
   ent_t        dlv[$];
   logic [15:0] m_pc;
   int          m_st;   // 0 idle, 1 fetching, 2 halted
   logic [15:0] exp_words [6];

   function automatic logic [15:0] memf(input logic [15:0] a);
      if (a == 16'h0000) return 16'h00FF;
      if (a == 16'h0005) return 16'hFFFF;
      return a + 16'h1000;
   endfunction

   assign mem_data = memf(mem_addr);

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .halted      (halted)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("valid", 32'(instr_valid), 32'(q.size() > 0));
      check("mem_addr", 32'(mem_addr), 32'(m_pc));
      check("halted", 32'(halted), 32'(m_st == 2));
      if (q.size() > 0) begin
         check("instr", 32'(instr), 32'(q[0].data));
         check("instr_pc", 32'(instr_pc), 32'(q[0].pc));
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc = 16'h0000;
      m_st = 0;
   endtask

   // one clock: drive inputs, advance the model by the rules, compare after the edge
   task automatic step(input logic s, input logic r, input logic [15:0] rpc, input logic rdy);
      logic pop;
      logic cap;
      ent_t e;
      start = s; redirect = r; redirect_pc = rpc; instr_ready = rdy;
      pop = (q.size() > 0) && rdy;
      if (r) begin
         q.delete();
         m_pc = rpc;
         m_st = 1;
      end else begin
         cap = (m_st == 1) && ((q.size() < DEPTH) || pop);
         if (pop) begin
            e = q.pop_front();
            dlv.push_back(e);
         end
         if (cap) begin
            q.push_back({memf(m_pc), m_pc});
            if (memf(m_pc) == 16'hFFFF) m_st = 2;
            m_pc = m_pc + 16'd1;
         end else if ((m_st == 0) && s) begin
            m_st = 1;
         end
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      start = 1'b0; redirect = 1'b0; instr_ready = 1'b0; redirect_pc = 16'h0000;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_instr", 32'(instr), 32'h0);
      check("rst_instr_pc", 32'(instr_pc), 32'h0);
      compare_all();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      exp_words[0] = 16'h00FF; exp_words[1] = 16'h1001; exp_words[2] = 16'h1002;
      exp_words[3] = 16'h1003; exp_words[4] = 16'h1004; exp_words[5] = 16'hFFFF;
      model_reset();
      #2;
      do_reset();

      // 1: straight run to the halt word
      dlv.delete();
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      repeat (9) step(1'b0, 1'b0, 16'h0000, 1'b1);
      check("run_count", 32'(dlv.size()), 32'd6);
      for (int i = 0; i < 6 && i < dlv.size(); i++) begin
         check("run_pc", 32'(dlv[i].pc), 32'(i));
         check("run_word", 32'(dlv[i].data), 32'(exp_words[i]));
      end
      check("run_halted", 32'(halted), 32'd1);

      // 2: stall decode, buffer fills, then drains in order
      do_reset();
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      repeat (4) step(1'b0, 1'b0, 16'h0000, 1'b0);
      check("stall_addr", 32'(mem_addr), 32'(DEPTH));
      dlv.delete();
      repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b1);
      check("drain_count", 32'(dlv.size()), 32'd5);
      for (int i = 0; i < dlv.size(); i++) check("drain_pc", 32'(dlv[i].pc), 32'(i));

      // 3: redirect with a full buffer
      do_reset();
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'h0100, 1'b0);
      check("redir_flush", 32'(instr_valid), 32'd0);
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      check("redir_word", 32'(instr), 32'h1100);
      check("redir_pc", 32'(instr_pc), 32'h0100);

      // 4: halt, then resume by redirect
      step(1'b0, 1'b1, 16'h0003, 1'b1);
      repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b1);
      check("halt_again", 32'(halted), 32'd1);
      step(1'b0, 1'b1, 16'h0010, 1'b1);
      check("resume_halted", 32'(halted), 32'd0);
      dlv.delete();
      repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b1);
      check("resume_count", 32'(dlv.size()), 32'd2);
      if (dlv.size() == 2) begin
         check("resume_w0", 32'(dlv[0].data), 32'h1010);
         check("resume_w1", 32'(dlv[1].data), 32'h1011);
      end

      // 5: address wrap
      dlv.delete();
      step(1'b0, 1'b1, 16'hFFFE, 1'b1);
      repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b1);
      check("wrap_count", 32'(dlv.size()), 32'd4);
      if (dlv.size() == 4) begin
         check("wrap_pc0", 32'(dlv[0].pc), 32'hFFFE);
         check("wrap_pc1", 32'(dlv[1].pc), 32'hFFFF);
         check("wrap_pc2", 32'(dlv[2].pc), 32'h0000);
         check("wrap_pc3", 32'(dlv[3].pc), 32'h0001);
      end

      // 6: asynchronous reset in the middle of a stream
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_valid", 32'(instr_valid), 32'd0);
      check("async_addr", 32'(mem_addr), 32'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b1);

      // random traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic        s, r, rdy;
         logic [15:0] rpc;
         s   = ($urandom_range(0, 7) == 0);
         r   = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 0) rpc = 16'($urandom_range(0, 12));
         else                           rpc = 16'hFFF0 + 16'($urandom_range(0, 15));
         step(s, r, rpc, rdy);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
